// File: rtl/seq_multiplier_pkg.sv
// Shared ALU definitions: FSM state encoding and default operand width,
// used by the sequential multiplier and the divider.
package seq_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 64;

    typedef logic [1:0] alu_state_t;

    localparam alu_state_t ST_IDLE = 2'd0;
    localparam alu_state_t ST_RUN  = 2'd1;
    localparam alu_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/seq_multiplier_sign_cond.sv
// Sign conditioning: passes the value through, or returns its two's-complement
// negation when neg_i is set. Used both for |x| on the way in and for the final sign.
module sign_cond #(
    parameter int W = 64
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add sequential multiplier, signed or unsigned, producing the
// full 2*WIDTH product after WIDTH iterations on magnitudes.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    localparam int CW = $clog2(WIDTH + 1);

    alu_state_t         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mpl_q, mpl_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               sign_q, sign_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_signed;

    // Most-negative operands negate to themselves, which is the correct unsigned magnitude.
    sign_cond #(.W(WIDTH)) u_sign_a (
        .val_i (a),
        .neg_i (is_signed & a[WIDTH-1]),
        .val_o (a_mag)
    );

    sign_cond #(.W(WIDTH)) u_sign_b (
        .val_i (b),
        .neg_i (is_signed & b[WIDTH-1]),
        .val_o (b_mag)
    );

    sign_cond #(.W(2*WIDTH)) u_sign_p (
        .val_i ({acc_q, mpl_q}),
        .neg_i (sign_q),
        .val_o (prod_signed)
    );

    assign sum = {1'b0, acc_q} + (mpl_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mpl_d   = mpl_q;
        mcand_d = mcand_q;
        sign_d  = sign_q;
        prod_d  = prod_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = CW'(WIDTH);
                    acc_d   = '0;
                    mcand_d = a_mag;
                    mpl_d   = b_mag;
                    sign_d  = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    prod_d  = prod_signed;
                end else begin
                    // Multiplier bits shift out the bottom while product bits shift in from the top.
                    acc_d = sum[WIDTH:1];
                    mpl_d = {sum[0], mpl_q[WIDTH-1:1]};
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mpl_q   <= '0;
            mcand_q <= '0;
            sign_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mpl_q   <= mpl_d;
            mcand_q <= mcand_d;
            sign_q  <= sign_d;
            prod_q  <= prod_d;
        end
    end

    assign busy    = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done    = (state_q == ST_DONE);
    assign prod_hi = prod_q[2*WIDTH-1:WIDTH];
    assign prod_lo = prod_q[WIDTH-1:0];

endmodule
